// File: rtl/drw_regctrl_pkg.sv
// Shared register map and bit positions for the multi-channel draw register controller.
package drw_regctrl_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_STAT    = 5'h04;
    localparam logic [4:0] OFF_BUFSTAT = 5'h08;
    localparam logic [4:0] OFF_CMD     = 5'h0C;
    localparam logic [4:0] OFF_INT     = 5'h10;

    localparam logic [15:0] CH_STRIDE = 16'h0020;

    localparam int unsigned BIT_EXE    = 0;
    localparam int unsigned BIT_RST    = 1;
    localparam int unsigned BIT_BUSY   = 0;
    localparam int unsigned BIT_OVF    = 16;
    localparam int unsigned BIT_FULL   = 17;
    localparam int unsigned BIT_EMPTY  = 16;
    localparam int unsigned BIT_INTEN  = 0;
    localparam int unsigned BIT_INTCLR = 1;
    localparam int unsigned BIT_PEND   = 1;

endpackage

// File: rtl/drw_cmdfifo.sv
// First-word fall-through command FIFO; storage is not reset, only pointers and count.
module drw_cmdfifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_din,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [W-1:0]                 o_dout,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_cnt;

endmodule

// File: rtl/drw_regctrl_multi.sv
// Register front-end for NCH draw engines: control pulses, command FIFOs, status and interrupts.
module drw_regctrl_multi
    import drw_regctrl_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h2000
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [15:0]           WRADDR,
    input  logic [3:0]            BYTEEN,
    input  logic                  WREN,
    input  logic [31:0]           WDATA,
    input  logic [15:0]           RDADDR,
    input  logic                  RDEN,
    output logic [31:0]           RDATA,
    input  logic [NCH-1:0]        DRW_BUSY,
    input  logic [NCH-1:0]        DRW_DONE,
    output logic                  DRW_IRQ,
    output logic [NCH-1:0]        SOFT_RST,
    output logic [NCH-1:0]        DRW_START,
    output logic [NCH-1:0]        CMD_VALID,
    output logic [DATA_W*NCH-1:0] CMD_DATA,
    input  logic [NCH-1:0]        CMD_READY
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [NCH-1:0]    r_start;
    logic [NCH-1:0]    r_srst;
    logic [NCH-1:0]    r_ovf;
    logic [NCH-1:0]    r_pend;
    logic [NCH-1:0]    r_inten;
    logic [NCH-1:0]    r_done_d;
    logic              r_irq;
    logic [31:0]       r_rdata;

    logic [NCH-1:0]    w_ctrl_wr;
    logic [NCH-1:0]    w_srst;
    logic [NCH-1:0]    w_push;
    logic [NCH-1:0]    w_int_wr;
    logic [NCH-1:0]    w_full;
    logic [NCH-1:0]    w_empty;
    logic [NCH-1:0]    w_rd_sel;
    logic [4:0]        w_rd_off [NCH];
    logic [CW-1:0]     w_count  [NCH];
    logic [DATA_W-1:0] w_dout   [NCH];
    logic [31:0]       w_rd_data;
    logic              w_unused_be;

    assign w_unused_be = ^BYTEEN[3:1];

    // Per-channel address decode and command FIFO.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [15:0] CH_BASE = BASE_ADDR + 16'(c) * CH_STRIDE;
        logic [15:0] w_wr_rel;
        logic [15:0] w_rd_rel;
        logic        w_wr_hit;

        assign w_wr_rel     = WRADDR - CH_BASE;
        assign w_rd_rel     = RDADDR - CH_BASE;
        assign w_wr_hit     = WREN && (w_wr_rel < CH_STRIDE);
        assign w_ctrl_wr[c] = w_wr_hit && (w_wr_rel[4:0] == OFF_CTRL) && BYTEEN[0];
        assign w_push[c]    = w_wr_hit && (w_wr_rel[4:0] == OFF_CMD);
        assign w_int_wr[c]  = w_wr_hit && (w_wr_rel[4:0] == OFF_INT) && BYTEEN[0];
        assign w_srst[c]    = w_ctrl_wr[c] && WDATA[BIT_RST];
        assign w_rd_sel[c]  = (w_rd_rel < CH_STRIDE);
        assign w_rd_off[c]  = w_rd_rel[4:0];

        drw_cmdfifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DATA_W)
        ) u_fifo (
            .i_clk   (CLK),
            .i_rstn  (RSTN),
            .i_push  (w_push[c]),
            .i_din   (WDATA),
            .i_pop   (CMD_READY[c]),
            .i_flush (w_srst[c]),
            .o_dout  (w_dout[c]),
            .o_count (w_count[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );

        assign CMD_DATA[DATA_W*c +: DATA_W] = w_dout[c];
        assign CMD_VALID[c]                 = !w_empty[c];
    end

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_rd_sel[c]) begin
                case (w_rd_off[c])
                    OFF_STAT: begin
                        w_rd_data[BIT_OVF]  = r_ovf[c];
                        w_rd_data[BIT_BUSY] = DRW_BUSY[c];
                    end
                    OFF_BUFSTAT: begin
                        w_rd_data[BIT_FULL]  = w_full[c];
                        w_rd_data[BIT_EMPTY] = w_empty[c];
                        w_rd_data[15:0]      = 16'(w_count[c]);
                    end
                    OFF_INT: begin
                        w_rd_data[BIT_PEND]  = r_pend[c];
                        w_rd_data[BIT_INTEN] = r_inten[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_start  <= '0;
            r_srst   <= '0;
            r_ovf    <= '0;
            r_pend   <= '0;
            r_inten  <= '0;
            r_done_d <= '0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_start  <= w_ctrl_wr & {NCH{WDATA[BIT_EXE]}};
            r_srst   <= w_srst;
            r_done_d <= DRW_DONE;
            r_irq    <= |(r_pend & r_inten);
            if (RDEN) r_rdata <= w_rd_data;
            for (int c = 0; c < NCH; c++) begin
                if (w_srst[c])                    r_ovf[c] <= 1'b0;
                else if (w_push[c] && w_full[c])  r_ovf[c] <= 1'b1;
                // Soft reset dominates; a new DONE edge beats a software clear.
                if (w_srst[c])                              r_pend[c] <= 1'b0;
                else if (DRW_DONE[c] && !r_done_d[c])       r_pend[c] <= 1'b1;
                else if (w_int_wr[c] && WDATA[BIT_INTCLR])  r_pend[c] <= 1'b0;
                if (w_int_wr[c]) r_inten[c] <= WDATA[BIT_INTEN];
            end
        end
    end

    assign RDATA     = r_rdata;
    assign DRW_IRQ   = r_irq;
    assign SOFT_RST  = r_srst;
    assign DRW_START = r_start;

endmodule

// File: tb/tb_drw_regctrl_multi.sv
// Directed bench for drw_regctrl_multi (NCH=2, depth 16) with read and command scoreboards.
module tb_drw_regctrl_multi;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;
    logic [1:0]  DRW_BUSY;
    logic [1:0]  DRW_DONE;
    logic        DRW_IRQ;
    logic [1:0]  SOFT_RST;
    logic [1:0]  DRW_START;
    logic [1:0]  CMD_VALID;
    logic [63:0] CMD_DATA;
    logic [1:0]  CMD_READY;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] q_rd[$];
    logic [31:0] q_cmd0[$];
    logic [31:0] q_cmd1[$];
    logic [1:0]  m_ovf;

    always #5 CLK = ~CLK;

    drw_regctrl_multi #(
        .NCH        (2),
        .FIFO_DEPTH (16),
        .BASE_ADDR  (16'h2000)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .WRADDR    (WRADDR),
        .BYTEEN    (BYTEEN),
        .WREN      (WREN),
        .WDATA     (WDATA),
        .RDADDR    (RDADDR),
        .RDEN      (RDEN),
        .RDATA     (RDATA),
        .DRW_BUSY  (DRW_BUSY),
        .DRW_DONE  (DRW_DONE),
        .DRW_IRQ   (DRW_IRQ),
        .SOFT_RST  (SOFT_RST),
        .DRW_START (DRW_START),
        .CMD_VALID (CMD_VALID),
        .CMD_DATA  (CMD_DATA),
        .CMD_READY (CMD_READY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        tick();
        WREN = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        q_rd.push_back(exp);
        RDADDR = a; RDEN = 1'b1;
        tick();
        RDEN = 1'b0;
        check(tag, RDATA, q_rd.pop_front());
    endtask

    task automatic push(input int ch, input logic [31:0] d, input logic [3:0] be);
        if (ch == 0) begin
            if (q_cmd0.size() < 16) q_cmd0.push_back(d); else m_ovf[0] = 1'b1;
            wr(16'h200C, d, be);
        end else begin
            if (q_cmd1.size() < 16) q_cmd1.push_back(d); else m_ovf[1] = 1'b1;
            wr(16'h202C, d, be);
        end
    endtask

    function automatic logic [31:0] bufstat(input int sz);
        return (sz == 16 ? 32'h0002_0000 : 32'h0) | (sz == 0 ? 32'h0001_0000 : 32'h0) | 32'(sz);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
        RDADDR = '0; RDEN = 1'b0; DRW_BUSY = '0; DRW_DONE = '0; CMD_READY = '0;
        m_ovf = '0;
        tick(); tick();
        check("rst_rdata", RDATA, 32'h0);
        check("rst_irq", 32'(DRW_IRQ), 32'h0);
        check("rst_start", 32'(DRW_START), 32'h0);
        check("rst_softrst", 32'(SOFT_RST), 32'h0);
        check("rst_valid", 32'(CMD_VALID), 32'h0);
        RSTN = 1'b1;
        tick();

        rd("bufstat0_init", 16'h2008, bufstat(0));
        rd("unmapped_0x14", 16'h2014, 32'h0);
        rd("bufstat1_init", 16'h2028, bufstat(0));
        rd("no_channel2", 16'h2048, 32'h0);
        rd("stat0_init", 16'h2004, 32'h0);

        // Start pulses
        wr(16'h2000, 32'h1, 4'hF);
        check("start_ch0", 32'(DRW_START), 32'h1);
        tick();
        check("start_ch0_end", 32'(DRW_START), 32'h0);
        wr(16'h2020, 32'h1, 4'hF);
        check("start_ch1", 32'(DRW_START), 32'h2);
        tick();
        check("start_ch1_end", 32'(DRW_START), 32'h0);
        wr(16'h2000, 32'h1, 4'hE);
        check("start_no_be0", 32'(DRW_START), 32'h0);

        // Overflow fill of channel 0
        for (int i = 0; i < 17; i++) push(0, 32'h100 + 32'(i), 4'hF);
        rd("bufstat0_full", 16'h2008, bufstat(q_cmd0.size()));
        rd("stat0_ovf", 16'h2004, {15'h0, m_ovf[0], 16'h0});
        DRW_BUSY = 2'b01;
        rd("stat0_ovf_busy", 16'h2004, {15'h0, m_ovf[0], 15'h0, 1'b1});
        DRW_BUSY = 2'b00;
        rd("stat1_clean", 16'h2024, 32'h0);
        rd("ctrl_wo", 16'h2000, 32'h0);
        CMD_READY = 2'b01;
        for (int i = 0; i < 16; i++) begin
            check("pop0_valid", 32'(CMD_VALID[0]), 32'h1);
            check("pop0_data", CMD_DATA[31:0], q_cmd0.pop_front());
            tick();
        end
        CMD_READY = 2'b00;
        check("pop0_empty", 32'(CMD_VALID[0]), 32'h0);

        // Streaming through channel 1 with the consumer always ready
        CMD_READY = 2'b10;
        for (int i = 0; i < 40; i++) begin
            WRADDR = 16'h202C; WDATA = 32'h1000 + 32'(i); BYTEEN = 4'hF; WREN = 1'b1;
            RDADDR = 16'h2028; RDEN = 1'b1;
            q_cmd1.push_back(WDATA);
            q_rd.push_back(i == 0 ? bufstat(0) : bufstat(1));
            tick();
            check("stream_count", RDATA, q_rd.pop_front());
            check("stream_valid", 32'(CMD_VALID[1]), 32'h1);
            check("stream_data", CMD_DATA[63:32], q_cmd1.pop_front());
        end
        WREN = 1'b0; RDEN = 1'b0;
        tick();
        check("stream_drained", 32'(CMD_VALID[1]), 32'h0);
        CMD_READY = 2'b00;

        // Interrupts on channel 1
        wr(16'h2030, 32'h1, 4'hF);
        DRW_DONE = 2'b10;
        tick();
        check("irq_after1", 32'(DRW_IRQ), 32'h0);
        tick();
        check("irq_after2", 32'(DRW_IRQ), 32'h1);
        rd("int1_pend", 16'h2030, 32'h3);
        DRW_DONE = 2'b00;
        wr(16'h2030, 32'h3, 4'hF);
        tick();
        check("irq_cleared", 32'(DRW_IRQ), 32'h0);
        rd("int1_clr", 16'h2030, 32'h1);
        DRW_DONE = 2'b10;
        wr(16'h2030, 32'h3, 4'hF);
        rd("int1_set_wins", 16'h2030, 32'h3);
        DRW_DONE = 2'b00;
        wr(16'h2030, 32'h2, 4'hF);
        tick();
        check("irq_off", 32'(DRW_IRQ), 32'h0);
        rd("int1_off", 16'h2030, 32'h0);

        // Soft reset of channel 0 leaves channel 1 alone and keeps INTEN
        wr(16'h2010, 32'h1, 4'h1);
        for (int i = 0; i < 5; i++) push(0, 32'h500 + 32'(i), 4'hF);
        push(1, 32'hA0, 4'h0);
        push(1, 32'hA1, 4'h0);
        rd("bufstat0_five", 16'h2008, bufstat(q_cmd0.size()));
        wr(16'h2000, 32'h2, 4'hF);
        q_cmd0.delete();
        m_ovf[0] = 1'b0;
        check("softrst_pulse", 32'(SOFT_RST), 32'h1);
        check("softrst_nostart", 32'(DRW_START), 32'h0);
        tick();
        check("softrst_end", 32'(SOFT_RST), 32'h0);
        rd("bufstat0_flushed", 16'h2008, bufstat(q_cmd0.size()));
        rd("stat0_ovf_clr", 16'h2004, {15'h0, m_ovf[0], 16'h0});
        rd("int0_kept", 16'h2010, 32'h1);
        rd("bufstat1_kept", 16'h2028, bufstat(q_cmd1.size()));
        check("ch1_head", CMD_DATA[63:32], q_cmd1[0]);

        // Reset in mid-stream
        WRADDR = 16'h200C; WDATA = 32'hBEEF; BYTEEN = 4'hF; WREN = 1'b1;
        RDADDR = 16'h2028; RDEN = 1'b1; RSTN = 1'b0;
        tick();
        RSTN = 1'b1; WREN = 1'b0; RDEN = 1'b0;
        q_cmd0.delete(); q_cmd1.delete(); m_ovf = '0;
        check("mid_rst_valid", 32'(CMD_VALID), 32'h0);
        check("mid_rst_rdata", RDATA, 32'h0);
        check("mid_rst_irq", 32'(DRW_IRQ), 32'h0);
        check("mid_rst_start", 32'(DRW_START), 32'h0);
        check("mid_rst_softrst", 32'(SOFT_RST), 32'h0);
        rd("mid_rst_buf0", 16'h2008, bufstat(q_cmd0.size()));
        rd("mid_rst_buf1", 16'h2028, bufstat(q_cmd1.size()));
        rd("mid_rst_int0", 16'h2010, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/drw_regctrl_multi.md
DRW_REGCTRL_MULTI -- requirements
Module: drw_regctrl_multi

Interface
REQ-001 Parameter NCH, default 2: number of draw channels, legal range 1..4.
REQ-002 Parameter FIFO_DEPTH, default 16: command FIFO entries per channel, power of two, legal range 4..2048.
REQ-003 Parameter BASE_ADDR, default 16'h2000: address of the channel 0 register block; channel c occupies BASE_ADDR + c*16'h20.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 CLK  in  1  sole clock, all logic on rising edge.
REQ-006 RSTN  in  1  synchronous active-low reset.
REQ-007 WRADDR  in  16  write byte address.
REQ-008 BYTEEN  in  4  write byte enables.
REQ-009 WREN  in  1  write strobe, one cycle per access.
REQ-010 WDATA  in  32  write data.
REQ-011 RDADDR  in  16  read byte address.
REQ-012 RDEN  in  1  read strobe.
REQ-013 RDATA  out  32  read data, registered.
REQ-014 DRW_BUSY  in  NCH  per-channel engine busy.
REQ-015 DRW_DONE  in  NCH  per-channel completion level; a rising edge is the event.
REQ-016 DRW_IRQ  out  1  combined interrupt to CPU.
REQ-017 SOFT_RST  out  NCH  per-channel one-cycle soft-reset pulse.
REQ-018 DRW_START  out  NCH  per-channel one-cycle start pulse.
REQ-019 CMD_VALID  out  NCH  FIFO head valid.
REQ-020 CMD_DATA  out  32*NCH  FIFO head data; channel c is at bits [32c+31:32c].
REQ-021 CMD_READY  in  NCH  consumer pop; a pop occurs when VALID and READY are both high.

Function
REQ-022 Per-channel offsets SHALL be: CTRL 0x00 (WO), STAT 0x04, BUFSTAT 0x08, CMD 0x0C (WO), INT 0x10. Any other address SHALL read 0 and ignore writes.
REQ-023 A CTRL write with BYTEEN[0] SHALL pulse DRW_START[c] for one cycle on the next edge if WDATA[0]=1, and SOFT_RST[c] if WDATA[1]=1.
REQ-024 A CMD write SHALL push WDATA into FIFO c, regardless of BYTEEN, and only when count < FIFO_DEPTH at that edge. A simultaneous pop SHALL NOT make room for a push into a full FIFO.
REQ-025 A push to a full FIFO SHALL be dropped and SHALL set sticky STAT.OVF[c].
REQ-026 FIFO c SHALL be first-word fall-through: CMD_VALID[c]=(count!=0) and CMD_DATA shows the oldest entry. Write-to-VALID latency SHALL be 1 cycle.
REQ-027 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged. Pointers SHALL wrap modulo FIFO_DEPTH. Count width SHALL be $clog2(FIFO_DEPTH)+1.
REQ-028 A soft reset on channel c SHALL flush FIFO c and clear OVF[c] and PEND[c] on the same edge that SOFT_RST pulses. A push in that cycle SHALL be dropped. INTEN[c] SHALL be retained.
REQ-029 A rising edge of DRW_DONE[c], detected against a one-cycle delayed copy, SHALL set PEND[c]. Writing INT bit1=1 with BYTEEN[0] SHALL clear it. If set and clear occur together, set SHALL win.
REQ-030 An INT write with BYTEEN[0] SHALL load INTEN[c]=WDATA[0].
REQ-031 DRW_IRQ SHALL be registered: OR over c of (PEND[c] & INTEN[c]), 1 cycle after PEND is set.
REQ-032 Read latency SHALL be 1 cycle: RDATA is captured at the edge where RDEN=1, holds until the next RDEN, and WO registers read 0.
REQ-033 STAT SHALL read {OVF at bit16, BUSY at bit0}. BUFSTAT SHALL read {FULL at bit17, EMPTY at bit16, count zero-extended in [15:0]}. INT SHALL read {PEND at bit1, INTEN at bit0}.

Reset
REQ-034 While RSTN=0 at an edge, all pulses, IRQ, RDATA, counts, pointers, OVF, PEND, INTEN and the DONE delay register SHALL be 0.
REQ-035 Reset in mid-operation SHALL discard FIFO contents. FIFO storage RAM SHALL NOT need to be cleared.

Structure
REQ-036 Package drw_regctrl_pkg SHALL hold the register offsets, the channel stride 0x20 and the bit positions (EXE, RST, OVF, FULL, EMPTY, INTEN, INTCLR, PEND).
REQ-037 Sub-module drw_cmdfifo SHALL be parametrised by depth, instantiated once per channel, and provide push, pop, flush, count, full and empty.

Verification (NCH=2, FIFO_DEPTH=16)
REQ-038 Write 0x2000=0x1 -> DRW_START=2'b01 for exactly 1 cycle. Write 0x2020=0x1 -> DRW_START=2'b10.
REQ-039 Push 17 words 0x100..0x110 to 0x200C with CMD_READY=0 -> BUFSTAT=0x0002_0010, STAT bit16=1, and pops return 0x100..0x10F in order.
REQ-040 Hold CMD_READY=1 and push every cycle -> count stays at 1 and there is no loss over a 40-word run, including pointer wrap.
REQ-041 Write INT 0x2030=0x1, then raise DRW_DONE[1] -> DRW_IRQ=1 two cycles later. Issue a clear on the same cycle as a new edge -> PEND stays 1.
REQ-042 Fill channel 0 with 5 words, then write 0x2000=0x2 -> count=0, OVF=0, channel 1 unaffected.
REQ-043 Assert RSTN=0 for 1 cycle mid-stream -> all outputs 0 and BUFSTAT EMPTY=1 on both channels.
